// File: rtl/axi_llc_tag_res_merge.sv
// Tag-store response merger: queues lookup descriptors, pairs each with its in-order
// tag response, annotates way/evict/refill info and routes it to the hit or miss path.

package axi_llc_tag_res_merge_pkg;

  typedef struct packed {
    logic [31:0] SetAssociativity;
    logic [31:0] TagLength;
  } llc_cfg_t;

  localparam llc_cfg_t DefaultCfg = '{SetAssociativity: 32'd4, TagLength: 32'd8};

  typedef logic [3:0] dflt_way_ind_t;
  typedef logic [7:0] dflt_tag_t;

  typedef struct packed {
    logic [7:0]    id;
    dflt_way_ind_t way_ind;
    logic          evict;
    dflt_tag_t     evict_tag;
    logic          refill;
    logic          flush;
  } dflt_desc_t;

  typedef struct packed {
    dflt_way_ind_t indicator;
    logic          hit;
    logic          evict;
    dflt_tag_t     evict_tag;
  } dflt_store_res_t;

endpackage

module axi_llc_tag_res_merge
  import axi_llc_tag_res_merge_pkg::*;
#(
  parameter llc_cfg_t    Cfg         = DefaultCfg,
  parameter type         way_ind_t   = logic [Cfg.SetAssociativity-1:0],
  parameter type         desc_t      = dflt_desc_t,
  parameter type         store_res_t = dflt_store_res_t,
  parameter int unsigned MaxPending  = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  desc_t                           desc_i,
  input  logic                            desc_valid_i,
  output logic                            desc_ready_o,
  input  store_res_t                      res_i,
  input  logic                            res_valid_i,
  output logic                            res_ready_o,
  output desc_t                           hit_desc_o,
  output logic                            hit_valid_o,
  input  logic                            hit_ready_i,
  output desc_t                           miss_desc_o,
  output logic                            miss_valid_o,
  input  logic                            miss_ready_i,
  output logic [$clog2(MaxPending+1)-1:0] pending_o,
  output logic                            err_o
);

  localparam int unsigned PtrW = (MaxPending > 1) ? $clog2(MaxPending) : 1;
  localparam int unsigned CntW = $clog2(MaxPending + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  // Pointers wrap at MaxPending explicitly so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MaxPending - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  desc_t mem_q [MaxPending];
  ptr_t  wr_ptr_q, rd_ptr_q;
  cnt_t  count_q;
  logic  err_q;

  desc_t hit_desc_q, miss_desc_q;
  logic  hit_valid_q, miss_valid_q;

  logic  empty, push, pop, to_hit, hit_free, miss_free;
  desc_t head, ann;

  assign empty        = (count_q == '0);
  assign desc_ready_o = (count_q < cnt_t'(MaxPending));
  assign push         = desc_valid_i & desc_ready_o;
  assign head         = mem_q[rd_ptr_q];

  // A slot is free when empty or when it hands off this very cycle.
  assign hit_free     = ~hit_valid_q | hit_ready_i;
  assign miss_free    = ~miss_valid_q | miss_ready_i;
  assign to_hit       = res_i.hit & ~head.flush;
  assign res_ready_o  = res_valid_i & ~empty & (to_hit ? hit_free : miss_free);
  assign pop          = res_ready_o;

  always_comb begin
    ann           = head;
    ann.way_ind   = way_ind_t'(res_i.indicator);
    ann.refill    = ~res_i.hit & ~head.flush;
    ann.evict     = res_i.evict;
    ann.evict_tag = res_i.evict_tag;
    if (res_i.hit) begin
      ann.evict     = 1'b0;
      ann.evict_tag = '0;
    end
  end

  // NOTE: descriptor storage has no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= desc_i;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
      if (res_valid_i && empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_valid_q <= 1'b0;
      hit_desc_q  <= '0;
    end else if (pop && to_hit) begin
      hit_valid_q <= 1'b1;
      hit_desc_q  <= ann;
    end else if (hit_ready_i) begin
      hit_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_valid_q <= 1'b0;
      miss_desc_q  <= '0;
    end else if (pop && !to_hit) begin
      miss_valid_q <= 1'b1;
      miss_desc_q  <= ann;
    end else if (miss_ready_i) begin
      miss_valid_q <= 1'b0;
    end
  end

  assign hit_desc_o   = hit_desc_q;
  assign hit_valid_o  = hit_valid_q;
  assign miss_desc_o  = miss_desc_q;
  assign miss_valid_o = miss_valid_q;
  assign pending_o    = count_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_axi_llc_tag_res_merge.sv
// Randomized scoreboard bench for axi_llc_tag_res_merge: a queue-based reference model
// predicts handshakes and annotated descriptors; a checker process compares every cycle.

module tb_axi_llc_tag_res_merge;
  import axi_llc_tag_res_merge_pkg::*;

  localparam int Depth = 4;

  logic            clk = 1'b0;
  logic            rst_ni;
  dflt_desc_t      desc_i;
  logic            desc_valid_i;
  logic            desc_ready_o;
  dflt_store_res_t res_i;
  logic            res_valid_i;
  logic            res_ready_o;
  dflt_desc_t      hit_desc_o;
  logic            hit_valid_o;
  logic            hit_ready_i;
  dflt_desc_t      miss_desc_o;
  logic            miss_valid_o;
  logic            miss_ready_i;
  logic [2:0]      pending_o;
  logic            err_o;

  int checks   = 0;
  int failures = 0;
  int next_id  = 1;

  axi_llc_tag_res_merge #(.MaxPending(Depth)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .desc_i       (desc_i),
    .desc_valid_i (desc_valid_i),
    .desc_ready_o (desc_ready_o),
    .res_i        (res_i),
    .res_valid_i  (res_valid_i),
    .res_ready_o  (res_ready_o),
    .hit_desc_o   (hit_desc_o),
    .hit_valid_o  (hit_valid_o),
    .hit_ready_i  (hit_ready_i),
    .miss_desc_o  (miss_desc_o),
    .miss_valid_o (miss_valid_o),
    .miss_ready_i (miss_ready_i),
    .pending_o    (pending_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected descriptor as the hit-miss pipelines should see it.
  function automatic dflt_desc_t expect_out(input dflt_desc_t d, input dflt_store_res_t r);
    dflt_desc_t o = d;
    o.way_ind   = r.indicator;
    o.refill    = !r.hit && !d.flush;
    o.evict     = r.hit ? 1'b0 : r.evict;
    o.evict_tag = r.hit ? 8'h00 : r.evict_tag;
    return o;
  endfunction

  // ---------------- reference model + checker ----------------
  dflt_desc_t dq[$];
  dflt_desc_t hq[$];
  dflt_desc_t mq[$];
  bit         err_exp = 1'b0;

  always @(negedge clk) begin
    bit         exp_rr, tgt_hit, push_ok;
    dflt_desc_t d;
    #4;
    if (!rst_ni) begin
      dq.delete(); hq.delete(); mq.delete();
      err_exp = 1'b0;
      check("rst_pending",    64'(pending_o),    64'(0));
      check("rst_hit_valid",  64'(hit_valid_o),  64'(0));
      check("rst_miss_valid", 64'(miss_valid_o), 64'(0));
      check("rst_hit_desc",   64'(hit_desc_o),   64'(0));
      check("rst_miss_desc",  64'(miss_desc_o),  64'(0));
      check("rst_err",        64'(err_o),        64'(0));
    end else begin
      check("pending",    64'(pending_o),    64'(dq.size()));
      check("desc_ready", 64'(desc_ready_o), 64'(dq.size() < Depth));
      check("err",        64'(err_o),        64'(err_exp));
      check("hit_valid",  64'(hit_valid_o),  64'(hq.size() > 0));
      check("miss_valid", 64'(miss_valid_o), 64'(mq.size() > 0));
      if (hq.size() > 0) check("hit_desc",  64'(hit_desc_o),  64'(hq[0]));
      if (mq.size() > 0) check("miss_desc", 64'(miss_desc_o), 64'(mq[0]));

      exp_rr  = 1'b0;
      tgt_hit = 1'b0;
      if (res_valid_i && dq.size() > 0) begin
        tgt_hit = res_i.hit && !dq[0].flush;
        exp_rr  = tgt_hit ? (hq.size() == 0 || hit_ready_i) : (mq.size() == 0 || miss_ready_i);
      end
      check("res_ready", 64'(res_ready_o), 64'(exp_rr));
      if (res_valid_i && dq.size() == 0) err_exp = 1'b1;

      push_ok = desc_valid_i && (dq.size() < Depth);
      if (hq.size() > 0 && hit_ready_i)  void'(hq.pop_front());
      if (mq.size() > 0 && miss_ready_i) void'(mq.pop_front());
      if (exp_rr) begin
        d = dq.pop_front();
        if (tgt_hit) hq.push_back(expect_out(d, res_i));
        else         mq.push_back(expect_out(d, res_i));
      end
      if (push_ok) dq.push_back(desc_i);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Overwritten fields carry garbage so the annotation is actually exercised.
  task automatic mk_desc(input bit fl);
    desc_i           = dflt_desc_t'($urandom);
    desc_i.id        = 8'(next_id);
    desc_i.flush     = fl;
    next_id++;
  endtask

  task automatic set_res(input logic [3:0] ind, input bit hit, input bit ev, input logic [7:0] tag);
    res_i = '{indicator: ind, hit: hit, evict: ev, evict_tag: tag};
  endtask

  task automatic rand_res();
    set_res(4'(1 << $urandom_range(3)), 1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic drain();
    desc_valid_i = 1'b0;
    hit_ready_i  = 1'b1;
    miss_ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (pending_o == 0) break;
      res_valid_i = 1'b1;
      rand_res();
      step();
    end
    res_valid_i = 1'b0;
    check("drain_done", 64'(pending_o), 64'(0));
    step(); step();
  endtask

  initial begin
    rst_ni       = 1'b0;
    desc_i       = '0;
    desc_valid_i = 1'b0;
    res_i        = '0;
    res_valid_i  = 1'b0;
    hit_ready_i  = 1'b1;
    miss_ready_i = 1'b1;
    repeat (2) step();
    rst_ni = 1'b1;
    step();

    // A: lookup that hits in way 2
    desc_valid_i = 1'b1; mk_desc(1'b0); step();
    desc_valid_i = 1'b0; res_valid_i = 1'b1; set_res(4'b0100, 1'b1, 1'b1, 8'h55); step();
    res_valid_i = 1'b0; step(); step();

    // B: miss with eviction of tag 0x3A
    desc_valid_i = 1'b1; mk_desc(1'b0); step();
    desc_valid_i = 1'b0; res_valid_i = 1'b1; set_res(4'b0001, 1'b0, 1'b1, 8'h3A); step();
    res_valid_i = 1'b0; step(); step();

    // C: flush that reports a hit goes to the miss path
    desc_valid_i = 1'b1; mk_desc(1'b1); step();
    desc_valid_i = 1'b0; res_valid_i = 1'b1; set_res(4'b0010, 1'b1, 1'b0, 8'h00); step();
    res_valid_i = 1'b0; step(); step();

    // Fill: five pushes without responses, then pop with push at full and below full
    desc_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin mk_desc(1'b0); step(); end
    res_valid_i = 1'b1; set_res(4'b1000, 1'b0, 1'b0, 8'h11); mk_desc(1'b0); step();
    set_res(4'b0100, 1'b1, 1'b0, 8'h00); mk_desc(1'b0); step();
    drain();

    // Stall: miss slot held full blocks the next miss and the hit queued behind it
    hit_ready_i = 1'b1; miss_ready_i = 1'b0;
    desc_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin mk_desc(1'b0); step(); end
    desc_valid_i = 1'b0;
    res_valid_i = 1'b1; set_res(4'b0001, 1'b0, 1'b0, 8'h21); step();
    set_res(4'b0010, 1'b0, 1'b1, 8'h22);
    repeat (3) step();
    miss_ready_i = 1'b1; step();
    set_res(4'b1000, 1'b1, 1'b0, 8'h00); step();
    res_valid_i = 1'b0; step(); step();

    // Randomized traffic with random back-pressure on both paths
    for (int i = 0; i < 3000; i++) begin
      hit_ready_i  = ($urandom_range(3) != 0);
      miss_ready_i = ($urandom_range(3) != 0);
      desc_valid_i = 1'($urandom);
      mk_desc($urandom_range(3) == 0);
      res_valid_i  = (pending_o != 0) && 1'($urandom);
      rand_res();
      step();
    end
    drain();

    // Response with an empty queue: refused, sticky error
    res_valid_i = 1'b1; rand_res(); step();
    res_valid_i = 1'b0; repeat (3) step();

    // Reset in the middle of traffic with both slots occupied
    miss_ready_i = 1'b0; hit_ready_i = 1'b0;
    desc_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin mk_desc(1'b0); step(); end
    desc_valid_i = 1'b0;
    res_valid_i = 1'b1; set_res(4'b0001, 1'b0, 1'b1, 8'h44); step();
    set_res(4'b0010, 1'b1, 1'b0, 8'h00); step();
    res_valid_i = 1'b0;
    rst_ni = 1'b0; repeat (2) step();
    rst_ni = 1'b1; hit_ready_i = 1'b1; miss_ready_i = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
